// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready
// handshake with whole-pipeline stall, and a tag carried alongside each operation.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       CTRL,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(WIDTH);

  logic advance;
  logic unused_b;

  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;
  // Amount bits above SHW select multiples of WIDTH, i.e. no movement.
  assign unused_b = ^B[WIDTH-1:SHW];

  for (genvar gi = 0; gi < SHW; gi++) begin : stg
    localparam int SH = 1 << gi;

    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       c_in;
    logic [SHW-1:0]   a_in;
    logic [TAG_W-1:0] t_in;
    logic [WIDTH-1:0] moved;

    logic             v_reg;
    logic [WIDTH-1:0] data_reg;
    logic [1:0]       ctrl_reg;
    logic [SHW-1:0]   amt_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             unused_ok;

    if (gi == 0) begin : g_src
      assign v_in = in_valid;
      assign d_in = A;
      assign c_in = CTRL;
      assign a_in = B[SHW-1:0];
      assign t_in = in_tag;
    end else begin : g_src
      assign v_in = stg[gi-1].v_reg;
      assign d_in = stg[gi-1].data_reg;
      assign c_in = stg[gi-1].ctrl_reg;
      assign a_in = stg[gi-1].amt_reg;
      assign t_in = stg[gi-1].tag_reg;
    end

    // Low amount bits are consumed by earlier stages; last stage needs no ctrl.
    assign unused_ok = ^{amt_reg, ctrl_reg};

    always_comb begin
      case (c_in)
        2'b00:   moved = d_in << SH;
        2'b01:   moved = (d_in >> SH) | (d_in << (WIDTH - SH));
        2'b10:   moved = d_in >> SH;
        default: moved = $signed(d_in) >>> SH;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_reg    <= 1'b0;
        data_reg <= '0;
        ctrl_reg <= '0;
        amt_reg  <= '0;
        tag_reg  <= '0;
      end else if (advance) begin
        v_reg <= v_in;
        // Bubbles leave the payload registers untouched.
        if (v_in) begin
          data_reg <= a_in[gi] ? moved : d_in;
          ctrl_reg <= c_in;
          amt_reg  <= a_in;
          tag_reg  <= t_in;
        end
      end
    end
  end

  assign out_valid = stg[SHW-1].v_reg;
  assign OUT       = stg[SHW-1].data_reg;
  assign out_tag   = stg[SHW-1].tag_reg;
  assign out_zero  = ~|stg[SHW-1].data_reg;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, backpressure, async reset,
// randomized traffic against an advance-indexed history model, and a WIDTH 8 instance.
module tb_shift_pipe;

  localparam int SHW = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  CTRL = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] OUT;
  logic        out_zero;
  logic [3:0]  out_tag;

  logic        in8_valid = 1'b0;
  logic        in8_ready;
  logic [7:0]  A8 = '0;
  logic [7:0]  B8 = '0;
  logic [1:0]  CTRL8 = '0;
  logic [3:0]  tag8 = '0;
  logic        out8_valid;
  logic        out8_ready = 1'b1;
  logic [7:0]  OUT8;
  logic        out8_zero;
  logic [3:0]  out8_tag;

  int checks = 0;
  int failures = 0;

  // Model: one history entry per pipeline advance; output is the entry SHW advances old.
  logic        hv[$];
  logic [31:0] hd[$];
  logic [3:0]  ht[$];
  logic [31:0] obs_d[$];
  logic [3:0]  obs_t[$];
  logic        obs_z[$];

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CTRL(CTRL), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  shift_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in8_valid), .in_ready(in8_ready),
    .A(A8), .B(B8), .CTRL(CTRL8), .in_tag(tag8),
    .out_valid(out8_valid), .out_ready(out8_ready), .OUT(OUT8),
    .out_zero(out8_zero), .out_tag(out8_tag)
  );

  function automatic logic [31:0] ref_shift(logic [31:0] a, logic [31:0] b, logic [1:0] c);
    int s;
    s = int'(b % 32);
    case (c)
      2'b00:   return a << s;
      2'b01:   return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      2'b10:   return a >> s;
      default: return $signed(a) >>> s;
    endcase
  endfunction

  function automatic logic m_valid();
    if (hv.size() >= SHW) return hv[hv.size() - SHW];
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic compare();
    logic mv;
    int   idx;
    mv = m_valid();
    chk("in_ready", 32'(in_ready), 32'(!(mv && !out_ready)));
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (mv) begin
      idx = hv.size() - SHW;
      chk("OUT", OUT, hd[idx]);
      chk("out_tag", 32'(out_tag), 32'(ht[idx]));
      chk("out_zero", 32'(out_zero), 32'(hd[idx] == 32'd0));
    end
  endtask

  // Inputs are stable from the preceding negedge; compare on the following negedge.
  task automatic tick();
    logic stall;
    stall = m_valid() && !out_ready;
    if (out_valid && out_ready) begin
      obs_d.push_back(OUT);
      obs_t.push_back(out_tag);
      obs_z.push_back(out_zero);
      $display("xfer tag=%0d out=%h zero=%0b", out_tag, OUT, out_zero);
    end
    @(posedge clk);
    if (!stall) begin
      hv.push_back(in_valid);
      hd.push_back(ref_shift(A, B, CTRL));
      ht.push_back(in_tag);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(logic v, logic [31:0] a, logic [31:0] b, logic [1:0] c, logic [3:0] t);
    in_valid = v;
    A = a;
    B = b;
    CTRL = c;
    in_tag = t;
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_t.delete();
    obs_z.delete();
  endtask

  task automatic check_reset_vals(string tagname);
    chk({tagname, "_valid"}, 32'(out_valid), 32'd0);
    chk({tagname, "_out"}, OUT, 32'd0);
    chk({tagname, "_zero"}, 32'(out_zero), 32'd1);
    chk({tagname, "_tag"}, 32'(out_tag), 32'd0);
    chk({tagname, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [31:0] va [14] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0FFF0000,
                           32'hFFFF0000, 32'h0FFFFFFF, 32'h12345678, 32'h80000001,
                           32'h5, 32'h5, 32'h5, 32'h5, 32'h1, 32'h1};
  logic [31:0] vb [14] = '{32'h0D, 32'h01, 32'h1F, 32'h0D, 32'h0D, 32'h08, 32'h08,
                           32'h21, 32'h0, 32'h0, 32'h0, 32'h0, 32'h01, 32'h1F};
  logic [1:0]  vc [14] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10,
                           2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
  logic [31:0] vx [14] = '{32'h1FFFE000, 32'hFFFFFFFE, 32'h00000001, 32'h00007FF8,
                           32'hFFFFFFF8, 32'h000FFFFF, 32'h78123456, 32'h40000000,
                           32'h5, 32'h5, 32'h5, 32'h5, 32'h0, 32'h80000000};

  initial begin
    logic [31:0] held;
    int          lat;

    // Power-on reset
    #2;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors, back to back, full rate
    clear_obs();
    for (int i = 0; i < 14; i++) begin
      set_in(1'b1, va[i], vb[i], vc[i], 4'(i));
      tick();
    end
    set_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("vec_count", 32'(obs_d.size()), 32'd14);
    for (int i = 0; i < 14 && i < obs_d.size(); i++) begin
      chk($sformatf("vec%0d_out", i), obs_d[i], vx[i]);
      chk($sformatf("vec%0d_tag", i), 32'(obs_t[i]), 32'(i));
      chk($sformatf("vec%0d_zero", i), 32'(obs_z[i]), 32'(vx[i] == 32'd0));
    end

    // Backpressure: fill, stall 4 cycles with an input on offer, then drain
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h11111111 * (i + 1), 32'(i + 3), 2'b00, 4'(i));
      tick();
    end
    chk("bp_full", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    set_in(1'b1, 32'hDEADBEEF, 32'd4, 2'b01, 4'd9);
    held = OUT;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_stable", OUT, held);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    set_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_count", 32'(obs_t.size()), 32'd6);
    for (int i = 0; i < 5 && i < obs_t.size(); i++)
      chk($sformatf("bp_tag%0d", i), 32'(obs_t[i]), 32'(i));
    if (obs_t.size() == 6) begin
      chk("bp_late_tag", 32'(obs_t[5]), 32'd9);
      chk("bp_late_out", obs_d[5], 32'hFDEADBEE);
    end

    // Async reset while operations are in flight
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 32'hA5A5A5A5 + i, 32'(i), 2'(i), 4'(i + 1));
      tick();
    end
    set_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rst");
    hv.delete();
    hd.delete();
    ht.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 8; i++) tick();
    chk("rst_no_stale", 32'(obs_d.size()), 32'd0);

    // Latency after reset
    set_in(1'b1, 32'h0000FFFF, 32'h0D, 2'b00, 4'd7);
    lat = 0;
    tick();
    lat = 1;
    set_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("lat_out", OUT, 32'h1FFFE000);
    chk("lat_tag", 32'(out_tag), 32'd7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      set_in(1'($urandom_range(0, 3) != 0), $urandom, 32'($urandom_range(0, 255)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      tick();
    end
    out_ready = 1'b1;
    set_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0);
    for (int i = 0; i < 8; i++) tick();

    // WIDTH 8 instance
    chk("w8_ready", 32'(in8_ready), 32'd1);
    in8_valid = 1'b1;
    A8 = 8'h96;
    B8 = 8'h0B;
    CTRL8 = 2'b11;
    tag8 = 4'd1;
    tick();
    CTRL8 = 2'b01;
    tag8 = 4'd2;
    tick();
    in8_valid = 1'b0;
    chk("w8_not_yet", 32'(out8_valid), 32'd0);
    tick();
    chk("w8_valid_sra", 32'(out8_valid), 32'd1);
    chk("w8_sra", 32'(OUT8), 32'hF2);
    chk("w8_sra_tag", 32'(out8_tag), 32'd1);
    tick();
    chk("w8_valid_ror", 32'(out8_valid), 32'd1);
    chk("w8_ror", 32'(OUT8), 32'hD2);
    chk("w8_ror_tag", 32'(out8_tag), 32'd2);
    chk("w8_ror_zero", 32'(out8_zero), 32'd0);
    tick();
    chk("w8_empty", 32'(out8_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
